// File: rtl/fwd_pkg.sv
// Shared pipeline encodings: writeback-source codes and forwarding control-word layout,
// used by decode, execute and the forwarding controller.
package fwd_pkg;

  typedef enum logic [1:0] {
    WB_ADDPC = 2'b00,
    WB_MEM   = 2'b01,
    WB_ALU   = 2'b10,
    WB_IMM8  = 2'b11
  } wbsel_e;

  localparam int CW_W      = 5;
  localparam int CW_BNF    = 4;
  localparam int CW_FWD    = 3;
  localparam int CW_SRC    = 2;
  localparam int CW_SEL_HI = 1;
  localparam int CW_SEL_LO = 0;

  localparam logic CW_SRC_X = 1'b0;
  localparam logic CW_SRC_M = 1'b1;

  // Not forwarded: execute keeps its own operand and pipelined store data.
  localparam logic [CW_W-1:0] CW_NONE = 5'b10000;

  function automatic logic [CW_W-1:0] cw_fwd(input logic src, input wbsel_e sel);
    logic [CW_W-1:0] w;
    w                        = '0;
    w[CW_FWD]                = 1'b1;
    w[CW_SRC]                = src;
    w[CW_SEL_HI:CW_SEL_LO]   = sel;
    return w;
  endfunction

endpackage

// File: rtl/fwd_word.sv
// Forwarding word for one decode source operand; the youngest matching producer wins.
module fwd_word
  import fwd_pkg::*;
#(
  parameter int REGW = 3
) (
  input  logic            idValid_i,
  input  logic [REGW-1:0] idReg_i,
  input  logic            idUses_i,
  input  logic            xValid_i,
  input  logic            xWrEn_i,
  input  logic [REGW-1:0] xWrReg_i,
  input  wbsel_e          xWbSel_i,
  input  logic            mValid_i,
  input  logic            mWrEn_i,
  input  logic [REGW-1:0] mWrReg_i,
  input  wbsel_e          mWbSel_i,
  output logic [CW_W-1:0] word_o,
  output logic            loadUse_o
);

  logic rd;
  logic xHit;
  logic mHit;

  assign rd   = idValid_i & idUses_i;
  assign xHit = rd & xValid_i & xWrEn_i & (xWrReg_i == idReg_i);
  assign mHit = rd & mValid_i & mWrEn_i & (mWrReg_i == idReg_i);

  always_comb begin
    word_o = CW_NONE;
    if (xHit) begin
      word_o = cw_fwd(CW_SRC_X, xWbSel_i);
    end else if (mHit) begin
      word_o = cw_fwd(CW_SRC_M, mWbSel_i);
    end
  end

  // Load data only exists after memory, so an X-stage load cannot feed execute directly.
  assign loadUse_o = xHit & (xWbSel_i == WB_MEM);

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller: shadows the X and M stages, produces
// registered execute forwarding words and a combinational fetch/decode stall.
module fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int REGW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            idValid,
  input  logic [REGW-1:0] idRegA,
  input  logic [REGW-1:0] idRegB,
  input  logic            idUsesA,
  input  logic            idUsesB,
  input  logic            idWrEn,
  input  logic [REGW-1:0] idWrReg,
  input  logic [1:0]      idWbSel,
  input  logic            flush,
  output logic [4:0]      fwCntrlA,
  output logic [4:0]      fwCntrlB,
  output logic            stall,
  output logic [15:0]     stallCount
);

  typedef struct packed {
    logic            valid;
    logic            wrEn;
    logic [REGW-1:0] wrReg;
    wbsel_e          wbSel;
  } rec_t;

  rec_t            x_q, x_d, m_q;
  logic [CW_W-1:0] fwA_q, fwB_q;
  logic [CW_W-1:0] wordA, wordB;
  logic            luA, luB;
  logic [15:0]     stallCount_q, stallCount_d;

  fwd_word #(.REGW(REGW)) u_fwd_a (
    .idValid_i (idValid),
    .idReg_i   (idRegA),
    .idUses_i  (idUsesA),
    .xValid_i  (x_q.valid),
    .xWrEn_i   (x_q.wrEn),
    .xWrReg_i  (x_q.wrReg),
    .xWbSel_i  (x_q.wbSel),
    .mValid_i  (m_q.valid),
    .mWrEn_i   (m_q.wrEn),
    .mWrReg_i  (m_q.wrReg),
    .mWbSel_i  (m_q.wbSel),
    .word_o    (wordA),
    .loadUse_o (luA)
  );

  fwd_word #(.REGW(REGW)) u_fwd_b (
    .idValid_i (idValid),
    .idReg_i   (idRegB),
    .idUses_i  (idUsesB),
    .xValid_i  (x_q.valid),
    .xWrEn_i   (x_q.wrEn),
    .xWrReg_i  (x_q.wrReg),
    .xWbSel_i  (x_q.wbSel),
    .mValid_i  (m_q.valid),
    .mWrEn_i   (m_q.wrEn),
    .mWrReg_i  (m_q.wrReg),
    .mWbSel_i  (m_q.wbSel),
    .word_o    (wordB),
    .loadUse_o (luB)
  );

  // A flushed decode instruction is dead, so it can never cause a stall.
  assign stall = ~rst & ~flush & (luA | luB);

  always_comb begin
    x_d       = '0;
    x_d.valid = idValid;
    x_d.wrEn  = idWrEn;
    x_d.wrReg = idWrReg;
    x_d.wbSel = wbsel_e'(idWbSel);
  end

  // M always follows X so a stalled load drains into M and becomes forwardable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      m_q   <= '0;
      fwA_q <= CW_NONE;
      fwB_q <= CW_NONE;
    end else begin
      m_q <= x_q;
      if (flush || stall) begin
        x_q.valid <= 1'b0;
        fwA_q     <= CW_NONE;
        fwB_q     <= CW_NONE;
      end else begin
        x_q   <= x_d;
        fwA_q <= wordA;
        fwB_q <= wordB;
      end
    end
  end

  always_comb begin
    stallCount_d = stallCount_q;
    if (stall && (stallCount_q != 16'hFFFF)) begin
      stallCount_d = stallCount_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount_q <= 16'd0;
    end else begin
      stallCount_q <= stallCount_d;
    end
  end

  assign fwCntrlA   = fwA_q;
  assign fwCntrlB   = fwB_q;
  assign stallCount = stallCount_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: a history-based reference model predicts stall and
// the post-edge forwarding words/count; a monitor process pops and compares them.
module tb_fwd_ctrl;

  localparam int REGW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            idValid, idUsesA, idUsesB, idWrEn, flush;
  logic [REGW-1:0] idRegA, idRegB, idWrReg;
  logic [1:0]      idWbSel;
  logic [4:0]      fwCntrlA, fwCntrlB;
  logic            stall;
  logic [15:0]     stallCount;

  int checks = 0;
  int errors = 0;

  // Instructions issued to execute, youngest first: [0] is in X, [1] is in M.
  typedef struct { bit v; bit we; int rg; int sel; } ent_t;
  ent_t hist [2];
  int   cnt_m;

  bit          q_stall [$];
  logic [25:0] q_post  [$];

  fwd_ctrl #(.REGW(REGW)) dut (
    .clk        (clk),
    .rst        (rst),
    .idValid    (idValid),
    .idRegA     (idRegA),
    .idRegB     (idRegB),
    .idUsesA    (idUsesA),
    .idUsesB    (idUsesB),
    .idWrEn     (idWrEn),
    .idWrReg    (idWrReg),
    .idWbSel    (idWbSel),
    .flush      (flush),
    .fwCntrlA   (fwCntrlA),
    .fwCntrlB   (fwCntrlB),
    .stall      (stall),
    .stallCount (stallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hit(input ent_t e, input bit v, input bit uses, input int rg);
    return v && uses && e.v && e.we && (e.rg == rg);
  endfunction

  // Forward enable 8, M source adds 4, producer wbSel in the low bits; 16 = not forwarded.
  function automatic int exp_word(input bit v, input bit uses, input int rg);
    for (int i = 0; i < 2; i++) begin
      if (hit(hist[i], v, uses, rg)) return 8 + 4 * i + hist[i].sel;
    end
    return 16;
  endfunction

  task automatic drive(input bit r, input bit v, input int ra, input bit ua,
                       input int rb, input bit ub, input bit we, input int wr,
                       input int sel, input bit fl);
    bit   st;
    int   wa, wb;
    ent_t nw;
    @(negedge clk);
    rst = r; idValid = v; idRegA = ra[REGW-1:0]; idUsesA = ua;
    idRegB = rb[REGW-1:0]; idUsesB = ub; idWrEn = we; idWrReg = wr[REGW-1:0];
    idWbSel = sel[1:0]; flush = fl;
    #1;
    st = !r && !fl && (hist[0].sel == 1) && (hit(hist[0], v, ua, ra) || hit(hist[0], v, ub, rb));
    if (r) begin
      chk("async_rst_fwA", fwCntrlA, 5'b10000);
      chk("async_rst_fwB", fwCntrlB, 5'b10000);
      chk("async_rst_cnt", stallCount, 16'd0);
      hist[0] = '{0, 0, 0, 0};
      hist[1] = '{0, 0, 0, 0};
      cnt_m = 0; wa = 16; wb = 16;
    end else begin
      wa = exp_word(v, ua, ra);
      wb = exp_word(v, ub, rb);
      if (st || fl) begin
        nw = '{0, 0, 0, 0}; wa = 16; wb = 16;
      end else begin
        nw = '{v, we, wr, sel};
      end
      hist[1] = hist[0];
      hist[0] = nw;
      if (st && cnt_m < 65535) cnt_m++;
    end
    q_stall.push_back(st);
    q_post.push_back({wa[4:0], wb[4:0], cnt_m[15:0]});
  endtask

  initial begin : monitor
    bit          es;
    logic [25:0] ep;
    forever begin
      @(negedge clk); #3;
      if (q_stall.size() > 0) begin
        es = q_stall.pop_front();
        chk("stall", {31'd0, stall}, {31'd0, es});
      end
      @(posedge clk); #1;
      if (q_post.size() > 0) begin
        ep = q_post.pop_front();
        chk("fwCntrlA", {27'd0, fwCntrlA}, {27'd0, ep[25:21]});
        chk("fwCntrlB", {27'd0, fwCntrlB}, {27'd0, ep[20:16]});
        chk("stallCount", {16'd0, stallCount}, {16'd0, ep[15:0]});
      end
    end
  end

  initial begin : stim
    rst = 1'b1; idValid = 0; idRegA = '0; idRegB = '0; idUsesA = 0; idUsesB = 0;
    idWrEn = 0; idWrReg = '0; idWbSel = '0; flush = 0;
    cnt_m = 0;
    hist[0] = '{0, 0, 0, 0};
    hist[1] = '{0, 0, 0, 0};

    // Reset with a would-be hazard on the inputs.
    drive(1, 1, 2, 1, 2, 1, 1, 2, 1, 0);

    // Ex-to-ex ALU forward on A.
    drive(0, 1, 0, 0, 0, 0, 1, 3, 2, 0);
    drive(0, 1, 3, 1, 0, 0, 1, 4, 2, 0);
    chk("ex2ex_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("ex2ex_fwA", fwCntrlA, 5'b01010);

    // Load-use on B: one stall, then mem-to-ex from M.
    drive(0, 1, 0, 0, 0, 0, 1, 2, 1, 0);
    drive(0, 1, 0, 0, 2, 1, 1, 6, 2, 0);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    chk("lu_cnt", stallCount, 16'd1);
    drive(0, 1, 0, 0, 2, 1, 1, 6, 2, 0);
    chk("lu_nostall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("lu_fwB", fwCntrlB, 5'b01101);

    // Priority: r5 in M (ALU) and X (imm8).
    drive(0, 1, 0, 0, 0, 0, 1, 5, 2, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 5, 3, 0);
    drive(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("prio_fwA", fwCntrlA, 5'b01011);

    // Flush during a load-use hazard.
    drive(0, 1, 0, 0, 0, 0, 1, 2, 1, 0);
    drive(0, 1, 2, 1, 2, 1, 1, 6, 2, 1);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("flush_fwA", fwCntrlA, 5'b10000);
    chk("flush_cnt", stallCount, 16'd1);

    // Non-reading sources never stall.
    drive(0, 1, 0, 0, 0, 0, 1, 2, 1, 0);
    drive(0, 1, 2, 0, 2, 0, 1, 6, 2, 0);
    chk("nouse_stall", {31'd0, stall}, 32'd0);

    // Mid-operation reset with r1 writer in X.
    drive(0, 1, 0, 0, 0, 0, 1, 1, 2, 0);
    drive(1, 1, 1, 1, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 1, 1, 0, 0, 0, 0);
    chk("rst_nostall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("rst_fwA", fwCntrlA, 5'b10000);
    chk("rst_fwB", fwCntrlB, 5'b10000);

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      drive(0, ($urandom % 8) != 0, $urandom % 4, $urandom % 2, $urandom % 4, $urandom % 2,
            ($urandom % 4) != 0, $urandom % 4, $urandom % 4, ($urandom % 10) == 0);
    end

    // Saturation: preset the counter just below the top, then stall twice.
    @(posedge clk); #2;
    force dut.stallCount_q = 16'hFFFE;
    #1;
    release dut.stallCount_q;
    cnt_m = 65534;
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 0, 0, 0, 1, 2, 1, 0);
      drive(0, 1, 0, 0, 2, 1, 1, 6, 2, 0);
      drive(0, 1, 0, 0, 2, 1, 1, 6, 2, 0);
    end
    @(posedge clk); #1;
    chk("sat_cnt", stallCount, 16'hFFFF);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_stall_drained", q_stall.size(), 0);
    chk("sb_post_drained", q_post.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
